pipelined_subtractor_32bit: RTL and testbench

PIPELINED_SUBTRACTOR_32BIT -- requirements
Module: pipelined_subtractor_32bit

---
 rtl/pipelined_subtractor_32bit_pkg.sv | 16 +
 rtl/pipelined_subtractor_32bit_if.sv | 32 +++
 rtl/pipelined_subtractor_32bit_sub_8bit.sv | 19 +
 rtl/pipelined_subtractor_32bit.sv | 125 ++++++++++++
 tb/tb_pipelined_subtractor_32bit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_subtractor_32bit_pkg.sv
// Shared widths and the stage-4 result record for the pipelined subtractor.
package pipelined_subtractor_32bit_pkg;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 8;
  localparam int STAGES  = 4;

  // Everything the last stage registers together for the consumer.
  typedef struct packed {
    logic [DATA_W-1:0] diff;
    logic              bout;
    logic              overflow;
    logic              zero;
  } result_t;

endpackage

// File: rtl/pipelined_subtractor_32bit_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until that edge;
// ready may depend combinationally on the opposite side's ready, never on
// this side's valid.
interface pipelined_subtractor_32bit_if;
  import pipelined_subtractor_32bit_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] num_a;
  logic [DATA_W-1:0] num_b;
  logic              Bin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] diff;
  logic              Bout;
  logic              overflow;
  logic              zero;

  modport master (
    output in_valid, num_a, num_b, Bin, out_ready,
    input  in_ready, out_valid, diff, Bout, overflow, zero
  );

  modport slave (
    input  in_valid, num_a, num_b, Bin, out_ready,
    output in_ready, out_valid, diff, Bout, overflow, zero
  );

endinterface

// File: rtl/pipelined_subtractor_32bit_sub_8bit.sv
// One byte slice of the subtractor: a - b - b_in with borrow-out.
module sub_8bit
  import pipelined_subtractor_32bit_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               b_in,
  output logic [SLICE_W-1:0] diff,
  output logic               b_out
);

  logic [SLICE_W:0] w_full;

  // The extra top bit of the widened difference is the borrow.
  assign w_full = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, b_in};
  assign diff   = w_full[SLICE_W-1:0];
  assign b_out  = w_full[SLICE_W];

endmodule

// File: rtl/pipelined_subtractor_32bit.sv
// 32-bit subtractor split into four byte slices, one per pipeline stage.
// Upper operand bytes ride along in skew registers until their slice runs;
// finished low result bytes ride along until all four leave stage 4 together.
// The whole pipeline advances only when the output is not stalled.
module pipelined_subtractor_32bit
  import pipelined_subtractor_32bit_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  pipelined_subtractor_32bit_if.slave  bus
);

  logic        w_en;
  logic [7:0]  w_d0, w_d1, w_d2, w_d3;
  logic        w_bo0, w_bo1, w_bo2, w_bo3;
  result_t     w_res;

  logic        r_v1, r_v2, r_v3, r_v4;
  logic        r_br1, r_br2, r_br3;
  logic [7:0]  r_d1;
  logic [15:0] r_d2;
  logic [23:0] r_d3;
  logic [23:0] r_a1, r_b1;
  logic [15:0] r_a2, r_b2;
  logic [7:0]  r_a3, r_b3;
  result_t     r_res;

  // A valid result the consumer refuses freezes every stage.
  assign w_en          = !(r_v4 && !bus.out_ready);
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_v4;
  assign bus.diff      = r_res.diff;
  assign bus.Bout      = r_res.bout;
  assign bus.overflow  = r_res.overflow;
  assign bus.zero      = r_res.zero;

  sub_8bit u_slice0 (.a(bus.num_a[7:0]), .b(bus.num_b[7:0]), .b_in(bus.Bin),
                     .diff(w_d0), .b_out(w_bo0));
  sub_8bit u_slice1 (.a(r_a1[7:0]), .b(r_b1[7:0]), .b_in(r_br1),
                     .diff(w_d1), .b_out(w_bo1));
  sub_8bit u_slice2 (.a(r_a2[7:0]), .b(r_b2[7:0]), .b_in(r_br2),
                     .diff(w_d2), .b_out(w_bo2));
  sub_8bit u_slice3 (.a(r_a3), .b(r_b3), .b_in(r_br3),
                     .diff(w_d3), .b_out(w_bo3));

  // Assemble the final result; a[31]/b[31] are the top bits of the last skewed bytes.
  always_comb begin
    w_res          = '0;
    w_res.diff     = {w_d3, r_d3};
    w_res.bout     = w_bo3;
    w_res.overflow = (r_a3[7] != r_b3[7]) && (w_d3[7] != r_a3[7]);
    w_res.zero     = ({w_d3, r_d3} == '0);
  end

  // Stage 1: slice 0 from the live operands; capture upper bytes for later slices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1  <= 1'b0;
      r_br1 <= 1'b0;
      r_d1  <= '0;
      r_a1  <= '0;
      r_b1  <= '0;
    end else if (w_en) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_br1 <= w_bo0;
        r_d1  <= w_d0;
        r_a1  <= bus.num_a[31:8];
        r_b1  <= bus.num_b[31:8];
      end
    end
  end

  // Stage 2: slice 1; bytes 2-3 of the operands keep skewing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v2  <= 1'b0;
      r_br2 <= 1'b0;
      r_d2  <= '0;
      r_a2  <= '0;
      r_b2  <= '0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_br2 <= w_bo1;
        r_d2  <= {w_d1, r_d1};
        r_a2  <= r_a1[23:8];
        r_b2  <= r_b1[23:8];
      end
    end
  end

  // Stage 3: slice 2; only the top operand byte remains to be consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v3  <= 1'b0;
      r_br3 <= 1'b0;
      r_d3  <= '0;
      r_a3  <= '0;
      r_b3  <= '0;
    end else if (w_en) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_br3 <= w_bo2;
        r_d3  <= {w_d2, r_d2};
        r_a3  <= r_a2[15:8];
        r_b3  <= r_b2[15:8];
      end
    end
  end

  // Stage 4: slice 3 plus flags, registered as one result record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v4  <= 1'b0;
      r_res <= '0;
    end else if (w_en) begin
      r_v4 <= r_v3;
      if (r_v3) begin
        r_res <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_subtractor_32bit.sv
// Bench for pipelined_subtractor_32bit: directed vectors, a stalled stream,
// a mid-flight reset and a randomized back-pressure run, all checked by a
// scoreboard that pops expected results as the DUT presents them.
module tb_pipelined_subtractor_32bit;

  localparam int W = 35;   // {diff, Bout, overflow, zero}

  logic clk;
  logic reset;
  int   cyc;
  int   chk_cnt;
  int   pass_cnt;
  int   recv_cnt;
  int   stall_seen;
  int   ready_mode;      // 0: always ready, 1: stall window, 2: random
  int   stall_base;
  logic [W-1:0] exp_q[$];

  pipelined_subtractor_32bit_if bus ();

  pipelined_subtractor_32bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: the arithmetic definition of the outputs.
  function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic bin);
    longint unsigned ua, ub;
    logic [31:0] d;
    logic bo, ov, z;
    ua = longint'(a);
    ub = longint'(b) + longint'(bin);
    d  = a - b - {31'b0, bin};
    bo = (ua < ub);
    ov = (a[31] != b[31]) && (d[31] != a[31]);
    z  = (d == 32'h0);
    return {d, bo, ov, z};
  endfunction

  // ---------------- output-ready driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        1:       bus.out_ready = !((cyc - stall_base) >= 6 && (cyc - stall_base) <= 9);
        2:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_out;
    logic [W-1:0] cur;
    logic [W-1:0] exp;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      #2;
      cur = {bus.diff, bus.Bout, bus.overflow, bus.zero};
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
        if (prev_stall) begin
          check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
          check("stall_hold_data", 64'(cur), 64'(prev_out));
        end
        if (bus.out_valid && !bus.out_ready) stall_seen++;
        if (bus.out_valid && bus.out_ready) begin
          recv_cnt++;
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_output: got %h required no output", cur);
          end else begin
            exp = exp_q.pop_front();
            check("result", 64'(cur), 64'(exp));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = cur;
      end
    end
  end

  // ---------------- stimulus drivers ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin,
                      input logic [W-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.num_a    = a;
    bus.num_b    = b;
    bus.Bin      = bin;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk_cnt++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles required acceptance", n);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] a, b;
    logic bin;
    a   = $urandom;
    b   = $urandom;
    bin = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: b = a;
      1: a = 32'h0;
      2: b = a - 32'h1;
      default: ;
    endcase
    send(a, b, bin, model(a, b, bin));
  endtask

  // Called right after send() returns; the accepting edge counts as edge 1.
  task automatic check_latency(input string name);
    int n;
    n = 1;
    forever begin
      @(negedge clk);
      if (bus.out_valid || n >= 20) break;
      @(posedge clk);
      n++;
    end
    check(name, 64'(n), 64'd4);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    chk_cnt      = 0;
    pass_cnt     = 0;
    recv_cnt     = 0;
    stall_seen   = 0;
    ready_mode   = 0;
    stall_base   = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.num_a    = '0;
    bus.num_b    = '0;
    bus.Bin      = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_diff", 64'(bus.diff), 64'd0);
    check("rst_bout", 64'(bus.Bout), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vectors with literal expectations {diff, Bout, overflow, zero}.
    send(32'h00000005, 32'h00000003, 1'b0, {32'h00000002, 1'b0, 1'b0, 1'b0});
    check_latency("latency_basic");
    send(32'h01000000, 32'h00000001, 1'b0, {32'h00FFFFFF, 1'b0, 1'b0, 1'b0});
    send(32'h00000000, 32'h00000001, 1'b0, {32'hFFFFFFFF, 1'b1, 1'b0, 1'b0});
    send(32'h80000000, 32'h00000001, 1'b0, {32'h7FFFFFFF, 1'b0, 1'b1, 1'b0});
    send(32'h12345678, 32'h12345677, 1'b1, {32'h00000000, 1'b0, 1'b0, 1'b1});
    wait_drain("drain_directed");

    // 20 back-to-back operands with out_ready low for cycles 6-9.
    r0         = recv_cnt;
    stall_seen = 0;
    @(negedge clk);
    stall_base = cyc;
    ready_mode = 1;
    repeat (20) send_rand();
    wait_drain("drain_stream");
    ready_mode = 0;
    check("stream_count", 64'(recv_cnt - r0), 64'd20);
    check("stall_exercised", 64'(stall_seen != 0), 64'd1);

    // Reset with three transactions in flight.
    repeat (3) send_rand();
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_diff", 64'(bus.diff), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    r0 = recv_cnt;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_none_emerge", 64'(recv_cnt - r0), 64'd0);
    send(32'hDEADBEEF, 32'h0BADF00D, 1'b1, model(32'hDEADBEEF, 32'h0BADF00D, 1'b1));
    check_latency("latency_after_reset");
    wait_drain("drain_reset");

    // Randomized operands under random back-pressure with occasional bubbles.
    r0         = recv_cnt;
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_rand();
    end
    wait_drain("drain_random");
    ready_mode = 0;
    check("random_count", 64'(recv_cnt - r0), 64'd60);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
